// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronised release of NUM_CH active-high resets,
// qualified by a stable lock, staggered by STAGGER_CYCLES between channels.
module reset_sequencer #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SYNC_STAGES    = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lock_in,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned STAG_MAX = STAGGER_CYCLES * (NUM_CH - 1);
    localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned STAG_W   = (STAG_MAX < 1) ? 1 : $clog2(STAG_MAX + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_rst_sync;
    logic                     r_lock_meta;
    logic                     r_lock_sync;
    logic [HOLD_W-1:0]        r_hold_cnt;
    logic [STAG_W-1:0]        r_stag_cnt;
    logic [NUM_CH-1:0]        r_rst_out;
    logic                     r_done;

    logic                     w_rst_sync;
    logic                     w_abort;
    logic [STAG_W-1:0]        w_stag_next;

    // Channel k stays in reset until STAGGER_CYCLES*k edges after channel 0 released.
    function automatic logic [NUM_CH-1:0] f_mask(input logic [STAG_W-1:0] t);
        logic [NUM_CH-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            m[k] = (32'(t) < STAGGER_CYCLES * k);
        end
        return m;
    endfunction

    assign w_rst_sync  = r_rst_sync[SYNC_STAGES-1];
    assign w_abort     = ~r_lock_sync | sw_rst_req;
    assign w_stag_next = (32'(r_stag_cnt) >= STAG_MAX) ? r_stag_cnt
                                                       : r_stag_cnt + STAG_W'(1);

    // Reset release synchroniser: ones on assertion, zeros shift in after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= '1;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // Two-flop synchroniser for the asynchronous lock qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= lock_in;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Sequencing FSM with registered reset outputs and done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ASSERT;
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_rst_out  <= '1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (!w_rst_sync) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (w_abort) begin
                        r_hold_cnt <= '0;
                    end else if (32'(r_hold_cnt) + 32'd1 >= HOLD_CYCLES) begin
                        r_stag_cnt <= '0;
                        r_rst_out  <= f_mask('0);
                        if (STAG_MAX == 0) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RELEASE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (w_abort) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                        r_stag_cnt <= '0;
                        r_rst_out  <= '1;
                        r_done     <= 1'b0;
                    end else begin
                        r_stag_cnt <= w_stag_next;
                        r_rst_out  <= f_mask(w_stag_next);
                        if (32'(w_stag_next) == STAG_MAX) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_abort) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                        r_stag_cnt <= '0;
                        r_rst_out  <= '1;
                        r_done     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign busy    = |r_rst_out;
    assign done    = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized lock/sw/rst_n
// activity, each cycle compared against an event-level reference model.
module tb_reset_sequencer;

    localparam int unsigned SYNC = 3;
    localparam int unsigned HOLD = 16;

    logic       clk;
    logic       rst_n;
    logic       lock_in;
    logic       sw_rst_req;
    logic [3:0] rst8;
    logic       busy8;
    logic       done8;
    logic [3:0] rst0;
    logic       busy0;
    logic       done0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    reset_sequencer #(.NUM_CH(4), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .sw_rst_req(sw_rst_req),
        .rst_out(rst8), .busy(busy8), .done(done8)
    );

    reset_sequencer #(.NUM_CH(4), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .sw_rst_req(sw_rst_req),
        .rst_out(rst0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges since reset release, lock pipeline, phase
    // (0 held, 1 counting qualified cycles, 2 released) and edges since release.
    int       m_rs;
    bit [1:0] m_lp;
    int       m_phase;
    int       m_q;
    int       m_t;

    always @(posedge clk or negedge rst_n) begin : model
        bit ls;
        if (!rst_n) begin
            m_rs = 0; m_lp = 2'b00; m_phase = 0; m_q = 0; m_t = 0;
        end else begin
            ls = m_lp[1];
            case (m_phase)
                0: if (m_rs >= int'(SYNC)) begin m_phase = 1; m_q = 0; end
                1: begin
                    if (!ls || sw_rst_req) m_q = 0;
                    else if (m_q + 1 >= int'(HOLD)) begin m_phase = 2; m_t = 0; end
                    else m_q = m_q + 1;
                end
                default: begin
                    if (!ls || sw_rst_req) begin m_phase = 1; m_q = 0; m_t = 0; end
                    else if (m_t < 100000) m_t = m_t + 1;
                end
            endcase
            if (m_rs < int'(SYNC)) m_rs = m_rs + 1;
            m_lp = {m_lp[0], lock_in};
        end
    end

    function automatic logic [3:0] exp_rst(input int stag);
        logic [3:0] e;
        e = 4'hF;
        if (m_phase == 2) begin
            for (int k = 0; k < 4; k++) e[k] = (m_t < stag * k);
        end
        return e;
    endfunction

    function automatic logic exp_done(input int stag);
        return (m_phase == 2) && (m_t >= stag * 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare both instances against the model.
    task automatic step();
        @(posedge clk);
        #1;
        chk("model_rst_s8",  32'(rst8),  32'(exp_rst(8)));
        chk("model_busy_s8", 32'(busy8), 32'(|exp_rst(8)));
        chk("model_done_s8", 32'(done8), 32'(exp_done(8)));
        chk("model_rst_s0",  32'(rst0),  32'(exp_rst(0)));
        chk("model_busy_s0", 32'(busy0), 32'(|exp_rst(0)));
        chk("model_done_s0", 32'(done0), 32'(exp_done(0)));
    endtask

    // Short async reset pulse; the following posedge is edge 0.
    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("restart_rst_s8", 32'(rst8), 32'hF);
        chk("restart_done_s8", 32'(done8), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        lock_in = 1'b1;
        sw_rst_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_s8",  32'(rst8),  32'hF);
        chk("reset_busy_s8", 32'(busy8), 32'h1);
        chk("reset_done_s8", 32'(done8), 32'h0);
        chk("reset_rst_s0",  32'(rst0),  32'hF);

        // Nominal release sequence, staggered and simultaneous.
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 45; e++) begin
            step();
            if (e == 18) begin chk("nom_e18", 32'(rst8), 32'hF); chk("s0_e18", 32'(rst0), 32'hF); end
            if (e == 19) begin
                chk("nom_e19", 32'(rst8), 32'hE);
                chk("s0_e19_rst", 32'(rst0), 32'h0);
                chk("s0_e19_done", 32'(done0), 32'h1);
            end
            if (e == 27) chk("nom_e27", 32'(rst8), 32'hC);
            if (e == 35) chk("nom_e35", 32'(rst8), 32'h8);
            if (e == 42) chk("nom_e42_done", 32'(done8), 32'h0);
            if (e == 43) begin
                chk("nom_e43_rst", 32'(rst8), 32'h0);
                chk("nom_e43_done", 32'(done8), 32'h1);
                chk("nom_e43_busy", 32'(busy8), 32'h0);
            end
        end

        // Software reset pulse while running.
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("sw_rst", 32'(rst8), 32'hF);
        chk("sw_done", 32'(done8), 32'h0);
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 15) chk("sw_i15", 32'(rst8), 32'hF);
            if (i == 16) chk("sw_i16", 32'(rst8), 32'hE);
            if (i == 24) chk("sw_i24", 32'(rst8), 32'hC);
            if (i == 40) begin chk("sw_i40", 32'(rst8), 32'h0); chk("sw_i40_done", 32'(done8), 32'h1); end
        end

        // One-cycle lock drop at hold count 10 delays release by 13 edges.
        restart();
        for (int e = 0; e <= 40; e++) begin
            step();
            if (e == 13) lock_in = 1'b0;
            if (e == 14) lock_in = 1'b1;
            if (e == 31) chk("lock_e31", 32'(rst8), 32'hF);
            if (e == 32) chk("lock_e32", 32'(rst8), 32'hE);
            if (e == 40) chk("lock_e40", 32'(rst8), 32'hC);
        end

        // Sub-cycle rst_n glitch mid-release forces all resets without a clock.
        rst_n = 1'b0;
        #1;
        chk("glitch_rst", 32'(rst8), 32'hF);
        chk("glitch_busy", 32'(busy8), 32'h1);
        chk("glitch_done_s0", 32'(done0), 32'h0);
        #1;
        rst_n = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            step();
            if (e == 18) chk("glitch_e18", 32'(rst8), 32'hF);
            if (e == 19) chk("glitch_e19", 32'(rst8), 32'hE);
        end

        // No lock at all: outputs stay in reset.
        lock_in = 1'b0;
        restart();
        for (int i = 0; i < 200; i++) begin
            step();
            if (i % 50 == 49) begin
                chk("nolock_rst", 32'(rst8), 32'hF);
                chk("nolock_done", 32'(done8), 32'h0);
            end
        end
        lock_in = 1'b1;

        // Randomized lock drops, software requests and reset glitches.
        for (int i = 0; i < 2000; i++) begin
            step();
            sw_rst_req = ($urandom_range(0, 99) == 0);
            if (!lock_in) lock_in = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 79) == 0) lock_in = 1'b0;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rand_glitch_rst", 32'(rst8), 32'hF);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
